puzzle_sequencer: RTL and testbench
===================================

PUZZLE_SEQUENCER -- requirements
Module: puzzle_sequencer

Interface
REQ-001 Parameter NUM_SOLVERS, default 2, sets the number of parallel solver slots; the legal range is 1..8.
REQ-002 Parameter RESULT_WIDTH, default 16, sets the per-slot result width.
REQ-003 Parameter SUM_WIDTH, default 32, sets the output data and accumulator width; it SHALL be >= RESULT_WIDTH.
REQ-004 Parameter MODE, default 0, selects the output mode: 0 = one beat per record, 1 = a single summed beat at the end.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port rd_start, output, 1 bit: one-cycle pulse that requests the next record from the reader.
REQ-008 Port rd_done, input, 1 bit: reader pulse meaning the requested record is available.
REQ-009 Port rd_last, input, 1 bit: qualified by rd_done; high means this record is the final one.
REQ-010 Port sv_start, output, NUM_SOLVERS bits: one-hot pulse that starts slot i on the record just read.
REQ-011 Port sv_ready, input, NUM_SOLVERS bits: slot i result valid; held high until acknowledged.
REQ-012 Port sv_result, input, NUM_SOLVERS*RESULT_WIDTH bits: slot i result at bits [i*RESULT_WIDTH +: RESULT_WIDTH].
REQ-013 Port sv_ack, output, NUM_SOLVERS bits: one-hot pulse that releases slot i.
REQ-014 Ports wr_valid (output, 1), wr_data (output, SUM_WIDTH), wr_last (output, 1), wr_ready (input, 1) form the output valid/ready stream.
REQ-015 Port done, output, 1 bit: high after the final beat is accepted; held until rst.

Function
REQ-016 The fetch FSM SHALL have states INIT, READ, WAIT_READ, DISPATCH, HOLD, DONE.
REQ-017 INIT SHALL go to READ unconditionally, one cycle after rst deasserts.
REQ-018 READ SHALL assert rd_start for exactly one cycle, then go to WAIT_READ; an rd_done seen in READ itself SHALL also be accepted.
REQ-019 On rd_done, the FSM SHALL latch last_seen = rd_last and go to DISPATCH.
REQ-020 DISPATCH SHALL pulse sv_start[disp_ptr], wrap disp_ptr modulo NUM_SOLVERS, and increment occupancy.
REQ-021 Next-state after DISPATCH: HOLD if last_seen; else HOLD if occupancy (after this dispatch) = NUM_SOLVERS; else READ.
REQ-022 HOLD SHALL go to READ when occupancy < NUM_SOLVERS and !last_seen, and to DONE when the final write is accepted.
REQ-023 The slot dispatched in the cycle last_seen is set SHALL be tagged as the last slot.
REQ-024 Retirement SHALL run concurrently with fetch, strictly in order via retire_ptr; sv_ready on any other slot SHALL be ignored until that slot is at retire_ptr.
REQ-025 MODE 0: the cycle after sv_ready[retire_ptr] is sampled high, wr_valid SHALL rise with wr_data = the zero-extended result and wr_last = (slot is the tagged last slot).
REQ-026 MODE 0: wr_data and wr_last SHALL be held stable while wr_valid && !wr_ready.
REQ-027 MODE 0: on the wr_valid && wr_ready cycle, sv_ack[retire_ptr] SHALL pulse, occupancy SHALL decrement, and retire_ptr SHALL wrap-increment.
REQ-028 MODE 1: the cycle after sv_ready[retire_ptr] is sampled, sv_ack SHALL pulse and sum SHALL be updated to sum + result, modulo 2^SUM_WIDTH, with no write beat.
REQ-029 MODE 1: after the tagged last slot is acknowledged, exactly one beat SHALL be issued with wr_data = sum and wr_last = 1.
REQ-030 A dispatch and a retirement in the same cycle SHALL leave occupancy unchanged.
REQ-031 rd_done outside READ/WAIT_READ SHALL be ignored; at most one write beat SHALL be outstanding at a time.
REQ-032 DONE SHALL be terminal: done = 1, and rd_start, sv_start, sv_ack and wr_valid SHALL all be 0.

Reset
REQ-033 rst SHALL immediately force state INIT, and all outputs, disp_ptr, retire_ptr, occupancy, sum, last_seen and the last-slot tag to 0.
REQ-034 Asserting rst mid-operation SHALL abandon all in-flight records; no beat SHALL complete from pre-reset state.

Verification
REQ-035 NUM_SOLVERS=2, MODE=0, 3 records (last on 3rd), results 5,7,9 in order -> beats 5,7,9 with wr_last only on 9, then done=1.
REQ-036 Out-of-order completion: slot1 ready (result 3) 20 cycles before slot0 (result 4) -> beat 4 precedes beat 3.
REQ-037 Solvers never ready, 5 records pending -> exactly 2 rd_start pulses; the 3rd pulse only after the first sv_ack.
REQ-038 MODE=1, SUM_WIDTH=16, results 0xFFFF then 0x0002 (last) -> one beat, wr_data=0x0001, wr_last=1.
REQ-039 wr_ready held low 10 cycles with wr_valid high -> wr_data/wr_last stable, no sv_ack, and the beat completes on the cycle wr_ready rises.
REQ-040 rst pulsed while wr_valid=1 -> wr_valid=0 asynchronously; after release, rd_start pulses in the 2nd cycle.

Source files
------------

// File: rtl/puzzle_sequencer_if.sv
// Reader, solver-slot and output-stream signals of the puzzle sequencer.
// The master modport is the sequencer side; slave is the environment side.
interface puzzle_sequencer_if #(
  parameter int NUM_SOLVERS  = 2,
  parameter int RESULT_WIDTH = 16,
  parameter int SUM_WIDTH    = 32
);
  logic                                rd_start;
  logic                                rd_done;
  logic                                rd_last;
  logic [NUM_SOLVERS-1:0]              sv_start;
  logic [NUM_SOLVERS-1:0]              sv_ready;
  logic [NUM_SOLVERS*RESULT_WIDTH-1:0] sv_result;
  logic [NUM_SOLVERS-1:0]              sv_ack;
  logic                                wr_valid;
  logic [SUM_WIDTH-1:0]                wr_data;
  logic                                wr_last;
  logic                                wr_ready;

  modport master (
    output rd_start, sv_start, sv_ack, wr_valid, wr_data, wr_last,
    input  rd_done, rd_last, sv_ready, sv_result, wr_ready
  );

  modport slave (
    input  rd_start, sv_start, sv_ack, wr_valid, wr_data, wr_last,
    output rd_done, rd_last, sv_ready, sv_result, wr_ready
  );
endinterface

// File: rtl/puzzle_sequencer.sv
// Fetches records from a reader, dispatches them round-robin to solver slots,
// and retires results strictly in order as beats (MODE 0) or one summed beat (MODE 1).
module puzzle_sequencer #(
  parameter int NUM_SOLVERS  = 2,
  parameter int RESULT_WIDTH = 16,
  parameter int SUM_WIDTH    = 32,
  parameter int MODE         = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  puzzle_sequencer_if.master    bus,
  output logic                  done
);
  localparam int PTR_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam int OCC_W = $clog2(NUM_SOLVERS + 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NUM_SOLVERS - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(NUM_SOLVERS);

  typedef enum logic [2:0] {INIT, READ, WAIT_READ, DISPATCH, HOLD, DONE} state_t;

  state_t                  state, state_nx;
  logic [PTR_W-1:0]        disp_ptr, retire_ptr, last_tag_ptr;
  logic [OCC_W-1:0]        occupancy, occ_next;
  logic                    last_seen, last_tag_valid;
  logic [SUM_WIDTH-1:0]    sum;
  logic                    wr_valid_q, wr_last_q, ack_pend;
  logic [SUM_WIDTH-1:0]    wr_data_q;
  logic [RESULT_WIDTH-1:0] held_result;
  logic [RESULT_WIDTH-1:0] results [NUM_SOLVERS];
  logic [RESULT_WIDTH-1:0] slot_result;
  logic                    rd_start_c, dispatch, retire, beat_accept, final_accept;
  logic                    slot_ready, capture, is_last_slot;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_SOLVERS; i++) begin : g_res
    assign results[i] = bus.sv_result[i*RESULT_WIDTH +: RESULT_WIDTH];
  end

  // Only the slot at retire_ptr may retire; other ready slots wait their turn.
  assign slot_result  = results[retire_ptr];
  assign is_last_slot = last_tag_valid && (retire_ptr == last_tag_ptr);
  assign slot_ready   = bus.sv_ready[retire_ptr] && (occupancy != '0) && (state != DONE);
  assign capture      = slot_ready && !wr_valid_q && !ack_pend;
  assign dispatch     = (state == DISPATCH);
  assign beat_accept  = wr_valid_q && bus.wr_ready;
  assign retire       = (MODE == 0) ? beat_accept : ack_pend;
  assign final_accept = beat_accept && wr_last_q;
  assign occ_next     = occupancy + OCC_W'(dispatch) - OCC_W'(retire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    rd_start_c = 1'b0;
    case (state)
      INIT:      state_nx = READ;
      READ: begin
        rd_start_c = 1'b1;
        state_nx   = bus.rd_done ? DISPATCH : WAIT_READ;
      end
      WAIT_READ: if (bus.rd_done) state_nx = DISPATCH;
      DISPATCH:  state_nx = (last_seen || occ_next == OCC_FULL) ? HOLD : READ;
      HOLD: begin
        if (final_accept)                              state_nx = DONE;
        else if (occupancy < OCC_FULL && !last_seen)   state_nx = READ;
      end
      DONE:      state_nx = DONE;
      default:   state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_ptr       <= '0;
      retire_ptr     <= '0;
      occupancy      <= '0;
      last_seen      <= 1'b0;
      last_tag_valid <= 1'b0;
      last_tag_ptr   <= '0;
      sum            <= '0;
      wr_valid_q     <= 1'b0;
      wr_data_q      <= '0;
      wr_last_q      <= 1'b0;
      ack_pend       <= 1'b0;
      held_result    <= '0;
    end else begin
      occupancy <= occ_next;
      if ((state == READ || state == WAIT_READ) && bus.rd_done)
        last_seen <= bus.rd_last;
      if (dispatch) begin
        disp_ptr <= wrap_inc(disp_ptr);
        if (last_seen) begin
          last_tag_valid <= 1'b1;
          last_tag_ptr   <= disp_ptr;
        end
      end
      if (retire) retire_ptr <= wrap_inc(retire_ptr);
      if (MODE == 0) begin
        if (capture) begin
          wr_valid_q <= 1'b1;
          wr_data_q  <= SUM_WIDTH'(slot_result);
          wr_last_q  <= is_last_slot;
        end else if (beat_accept) begin
          wr_valid_q <= 1'b0;
        end
      end else begin
        // Results are folded into the sum on the ack cycle; only the last slot emits a beat.
        ack_pend <= capture;
        if (capture) held_result <= slot_result;
        if (ack_pend) begin
          sum <= sum + SUM_WIDTH'(held_result);
          if (is_last_slot) begin
            wr_valid_q <= 1'b1;
            wr_data_q  <= sum + SUM_WIDTH'(held_result);
            wr_last_q  <= 1'b1;
          end
        end else if (beat_accept) begin
          wr_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.rd_start = rd_start_c;
  assign bus.sv_start = dispatch ? (NUM_SOLVERS'(1) << disp_ptr) : '0;
  assign bus.sv_ack   = (retire && state != DONE) ? (NUM_SOLVERS'(1) << retire_ptr) : '0;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_last  = wr_last_q;
  assign done         = (state == DONE);
endmodule

// File: tb/tb_puzzle_sequencer.sv
// Scoreboard bench: instance 0 runs MODE 0 (32-bit sum), instance 1 runs MODE 1 (16-bit sum),
// each with a reader/solver model and a monitor popping expected beats.
module tb_puzzle_sequencer;
  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst_v      [2];
  logic        wr_rdy     [2];
  logic        done_v     [2];
  logic        rd_start_m [2];
  logic        wr_valid_m [2];
  logic        wr_last_m  [2];
  logic [31:0] wr_data_m  [2];
  logic [1:0]  sv_start_m [2];
  logic [1:0]  sv_ack_m   [2];

  int          num_rec  [2];
  int          rd_dly   [2];
  int          rs_count [2];
  int          ack_count[2];
  logic [15:0] res_tbl  [2][8];
  int          dly_tbl  [2][8];

  beat_t exp_q[$];
  int    checks_total  = 0;
  int    checks_passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : env
    localparam int SW = (g == 0) ? 32 : 16;

    puzzle_sequencer_if #(.NUM_SOLVERS(2), .RESULT_WIDTH(16), .SUM_WIDTH(SW)) bus ();

    puzzle_sequencer #(.NUM_SOLVERS(2), .RESULT_WIDTH(16), .SUM_WIDTH(SW), .MODE(g)) dut (
      .clk  (clk),
      .rst  (rst_v[g]),
      .bus  (bus),
      .done (done_v[g])
    );

    assign rd_start_m[g] = bus.rd_start;
    assign sv_start_m[g] = bus.sv_start;
    assign sv_ack_m[g]   = bus.sv_ack;
    assign wr_valid_m[g] = bus.wr_valid;
    assign wr_last_m[g]  = bus.wr_last;
    assign wr_data_m[g]  = 32'(bus.wr_data);
    assign bus.wr_ready  = wr_rdy[g];

    int          rec, rd_cnt, disp;
    int          cnt  [2];
    logic        busy [2];
    logic [15:0] rv   [2];

    // Reader answers each rd_start after rd_dly cycles; solvers go ready after their table delay.
    always @(negedge clk) begin
      logic [1:0] st, ak;
      logic       rs, fire;
      st = bus.sv_start;
      ak = bus.sv_ack;
      rs = bus.rd_start;
      if (rst_v[g]) begin
        rec = 0; rd_cnt = 0; disp = 0;
        rs_count[g] = 0; ack_count[g] = 0;
        bus.rd_done = 1'b0; bus.rd_last = 1'b0;
        bus.sv_ready = '0; bus.sv_result = '0;
        for (int i = 0; i < 2; i++) begin busy[i] = 1'b0; cnt[i] = 0; rv[i] = '0; end
      end else begin
        bus.rd_done = 1'b0;
        bus.rd_last = 1'b0;
        fire = 1'b0;
        if (rd_cnt > 0) begin
          rd_cnt--;
          fire = (rd_cnt == 0);
        end
        if (rs) begin
          rs_count[g]++;
          if (rec < num_rec[g]) begin
            if (rd_dly[g] == 0) fire = 1'b1;
            else rd_cnt = rd_dly[g];
          end
        end
        if (fire) begin
          bus.rd_done = 1'b1;
          bus.rd_last = (rec == num_rec[g] - 1);
          rec++;
        end
        for (int i = 0; i < 2; i++) begin
          if (ak[i]) begin
            bus.sv_ready[i] = 1'b0;
            busy[i] = 1'b0;
            ack_count[g]++;
          end
          if (st[i]) begin
            busy[i] = 1'b1;
            cnt[i]  = dly_tbl[g][disp & 7];
            rv[i]   = res_tbl[g][disp & 7];
            disp++;
          end else if (busy[i] && !bus.sv_ready[i]) begin
            if (cnt[i] == 0) begin
              bus.sv_ready[i] = 1'b1;
              bus.sv_result[i*16 +: 16] = rv[i];
            end else if (cnt[i] > 0) begin
              cnt[i]--;
            end
          end
        end
      end
    end

    // Monitor: every accepted beat must match the head of the scoreboard queue.
    always @(negedge clk) begin
      beat_t e;
      if (!rst_v[g] && bus.wr_valid && bus.wr_ready) begin
        if (exp_q.size() == 0) begin
          checks_total++;
          $display("[TB] FAIL unexpected_beat inst%0d: got data %0h, required no beat", g, bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("beat_data_inst%0d", g), 32'(bus.wr_data), e.data);
          checkOutput($sformatf("beat_last_inst%0d", g), 32'(bus.wr_last), 32'(e.last));
        end
      end
    end
  end

  task automatic expectBeat(input logic [31:0] data, input logic last);
    beat_t b;
    b.data = data;
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic applyStimulus(input int g, input int n, input logic [15:0] r0, r1, r2,
                               input int d0, d1, d2);
    for (int k = 0; k < 8; k++) begin res_tbl[g][k] = '0; dly_tbl[g][k] = -1; end
    res_tbl[g][0] = r0; res_tbl[g][1] = r1; res_tbl[g][2] = r2;
    dly_tbl[g][0] = d0; dly_tbl[g][1] = d1; dly_tbl[g][2] = d2;
    num_rec[g] = n;
    rd_dly[g]  = 2;
    @(posedge clk); #1;
    rst_v[g] = 1'b0;
  endtask

  task automatic resetDut(input int g, input string name);
    @(posedge clk); #1;
    rst_v[g] = 1'b1;
    checkOutput({name, "_queue_drained"}, 32'(exp_q.size()), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic waitDone(input int g, input int budget, input string name);
    int n = 0;
    while (!done_v[g] && n < budget) begin @(negedge clk); #1; n++; end
    checkOutput(name, 32'(done_v[g]), 1);
  endtask

  task automatic waitValid(input int g, input int budget, input string name);
    int n = 0;
    while (!wr_valid_m[g] && n < budget) begin @(negedge clk); #1; n++; end
    checkOutput(name, 32'(wr_valid_m[g]), 1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    wr_rdy[0] = 1'b1; wr_rdy[1] = 1'b1;
    for (int g = 0; g < 2; g++) begin
      num_rec[g] = 0; rd_dly[g] = 2;
      for (int k = 0; k < 8; k++) begin res_tbl[g][k] = '0; dly_tbl[g][k] = -1; end
    end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("reset_rd_start", 32'(rd_start_m[0]), 0);
    checkOutput("reset_sv_start", 32'(sv_start_m[0]), 0);
    checkOutput("reset_sv_ack",   32'(sv_ack_m[0]), 0);
    checkOutput("reset_wr_valid", 32'(wr_valid_m[0]), 0);
    checkOutput("reset_done",     32'(done_v[0]), 0);

    $display("[TB] three records, in-order results");
    expectBeat(32'd5, 1'b0);
    expectBeat(32'd7, 1'b0);
    expectBeat(32'd9, 1'b1);
    applyStimulus(0, 3, 16'd5, 16'd7, 16'd9, 3, 3, 3);
    waitDone(0, 300, "t1_done");
    repeat (3) @(negedge clk); #1;
    checkOutput("t1_done_held",      32'(done_v[0]), 1);
    checkOutput("t1_done_rd_start",  32'(rd_start_m[0]), 0);
    checkOutput("t1_done_sv_start",  32'(sv_start_m[0]), 0);
    checkOutput("t1_done_sv_ack",    32'(sv_ack_m[0]), 0);
    checkOutput("t1_done_wr_valid",  32'(wr_valid_m[0]), 0);
    resetDut(0, "t1");

    $display("[TB] slot1 finishes long before slot0");
    expectBeat(32'd4, 1'b0);
    expectBeat(32'd3, 1'b1);
    applyStimulus(0, 2, 16'd4, 16'd3, 16'd0, 30, 2, 0);
    waitDone(0, 300, "t2_done");
    resetDut(0, "t2");

    $display("[TB] solvers stall with five records pending");
    expectBeat(32'd11, 1'b0);
    applyStimulus(0, 5, 16'd11, 16'd0, 16'd0, 50, -1, -1);
    repeat (40) @(negedge clk); #1;
    checkOutput("t3_rd_pulses_stalled", 32'(rs_count[0]), 2);
    checkOutput("t3_no_ack_stalled",    32'(ack_count[0]), 0);
    n = 0;
    while (ack_count[0] < 1 && n < 100) begin @(negedge clk); #1; n++; end
    checkOutput("t3_first_ack",         32'(ack_count[0]), 1);
    checkOutput("t3_rd_pulses_at_ack",  32'(rs_count[0]), 2);
    repeat (4) @(negedge clk); #1;
    checkOutput("t3_third_rd_pulse",    32'(rs_count[0]), 3);
    repeat (20) @(negedge clk); #1;
    checkOutput("t3_no_fourth_rd",      32'(rs_count[0]), 3);
    resetDut(0, "t3");

    $display("[TB] backpressure for ten cycles");
    wr_rdy[0] = 1'b0;
    expectBeat(32'h0000abcd, 1'b1);
    applyStimulus(0, 1, 16'habcd, 16'd0, 16'd0, 2, 0, 0);
    waitValid(0, 100, "t4_valid");
    for (int k = 0; k < 10; k++) begin
      checkOutput("t4_valid_held", 32'(wr_valid_m[0]), 1);
      checkOutput("t4_data_held",  wr_data_m[0], 32'h0000abcd);
      checkOutput("t4_last_held",  32'(wr_last_m[0]), 1);
      checkOutput("t4_no_ack",     32'(sv_ack_m[0]), 0);
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    wr_rdy[0] = 1'b1;
    @(negedge clk); #1;
    checkOutput("t4_ack_on_accept", 32'(sv_ack_m[0]), 32'h1);
    @(posedge clk); #1;
    checkOutput("t4_valid_dropped", 32'(wr_valid_m[0]), 0);
    waitDone(0, 50, "t4_done");
    resetDut(0, "t4");

    $display("[TB] reset while a beat is pending");
    wr_rdy[0] = 1'b0;
    applyStimulus(0, 2, 16'h0055, 16'h0056, 16'd0, 2, 2, 0);
    waitValid(0, 100, "t5_valid");
    @(posedge clk); #3;
    rst_v[0] = 1'b1;
    #1;
    checkOutput("t5_async_valid_clear", 32'(wr_valid_m[0]), 0);
    checkOutput("t5_async_done_clear",  32'(done_v[0]), 0);
    wr_rdy[0] = 1'b1;
    expectBeat(32'h77, 1'b0);
    expectBeat(32'h88, 1'b1);
    applyStimulus(0, 2, 16'h0077, 16'h0088, 16'd0, 2, 2, 0);
    @(negedge clk); #1;
    checkOutput("t5_rd_start_cycle1", 32'(rd_start_m[0]), 0);
    @(negedge clk); #1;
    checkOutput("t5_rd_start_cycle2", 32'(rd_start_m[0]), 1);
    @(negedge clk); #1;
    checkOutput("t5_rd_start_cycle3", 32'(rd_start_m[0]), 0);
    waitDone(0, 300, "t5_done");
    resetDut(0, "t5");

    $display("[TB] summing mode with wraparound");
    expectBeat(32'h0001, 1'b1);
    applyStimulus(1, 2, 16'hffff, 16'h0002, 16'd0, 2, 2, 0);
    waitDone(1, 300, "t6_done");
    checkOutput("t6_ack_count", 32'(ack_count[1]), 2);
    resetDut(1, "t6");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
